// File: rtl/tlight_safety_monitor.sv
// Traffic-light lamp safety monitor: registers controller aspects and forces flashing yellow on confirmed faults.
// Optional stuck-controller detector is built when TLIGHT_MON_STUCK_EN is defined.
//
// state    | meaning
// NORMAL   | lamps follow inputs with one cycle of latency
// SUSPECT  | fault seen, lamps held RED/RED while it is confirmed
// FAILSAFE | fault confirmed, lamps flash YELLOW/YELLOW and dark
// RECOVER  | operator cleared, lamps RED/RED until a clean window elapses
module tlight_safety_monitor #(
    parameter int FAULT_CONFIRM  = 2,
    parameter int FLASH_HALF     = 4,
    parameter int RECOVER_CYCLES = 8,
    parameter int STUCK_LIMIT    = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] ns_in,
    input  logic [2:0] we_in,
    input  logic       clear_fault,
    output logic [2:0] ns_lamp,
    output logic [2:0] we_lamp,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] trip_count
);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    localparam int CNT_W   = $clog2(FAULT_CONFIRM + 1);
    localparam int FLASH_W = $clog2(2 * FLASH_HALF);
    localparam int REC_W   = $clog2(RECOVER_CYCLES + 1);

    localparam logic [CNT_W-1:0]   CONFIRM_L  = CNT_W'(FAULT_CONFIRM);
    localparam logic [FLASH_W-1:0] HALF_L     = FLASH_W'(FLASH_HALF);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(2 * FLASH_HALF - 1);
    localparam logic [REC_W-1:0]   REC_L      = REC_W'(RECOVER_CYCLES);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_SUSPECT,
        ST_FAILSAFE,
        ST_RECOVER
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt,   w_cnt_inc;
    logic [FLASH_W-1:0] r_flash, w_flash_nxt;
    logic [REC_W-1:0]   r_rec,   w_rec_nxt,   w_rec_inc;
    logic [1:0]         r_code,  w_code_nxt;
    logic [7:0]         r_trip,  w_trip_nxt;
    logic [2:0]         r_ns_lamp, r_we_lamp, w_ns_lamp_nxt, w_we_lamp_nxt;
    logic               w_enter_fs;

    logic       w_ns_legal, w_we_legal, w_illegal, w_conflict, w_stuck, w_fault;
    logic [1:0] w_code;

    assign w_ns_legal = (ns_in == RED) || (ns_in == YELLOW) || (ns_in == GREEN);
    assign w_we_legal = (we_in == RED) || (we_in == YELLOW) || (we_in == GREEN);
    assign w_illegal  = !(w_ns_legal && w_we_legal);
    assign w_conflict = (ns_in != RED) && (we_in != RED);

`ifdef TLIGHT_MON_STUCK_EN
    localparam int STK_W = $clog2(STUCK_LIMIT + 1);
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_LIMIT);

    logic [5:0]       r_prev;
    logic [STK_W-1:0] r_stuck_cnt;
    logic [STK_W-1:0] w_run_len;
    logic             w_same;

    // Run length includes the current cycle and saturates at the limit.
    assign w_same = ({ns_in, we_in} == r_prev);
    always_comb begin
        w_run_len = STK_W'(1);
        if (w_same) begin
            if (r_stuck_cnt == STK_MAX) begin
                w_run_len = STK_MAX;
            end else begin
                w_run_len = r_stuck_cnt + STK_W'(1);
            end
        end
    end
    assign w_stuck = (w_run_len == STK_MAX);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prev      <= '0;
            r_stuck_cnt <= '0;
        end else begin
            r_prev <= {ns_in, we_in};
            if (r_state == ST_NORMAL || r_state == ST_SUSPECT) begin
                r_stuck_cnt <= w_run_len;
            end else begin
                r_stuck_cnt <= '0;
            end
        end
    end
`else
    assign w_stuck = 1'b0;
`endif

    always_comb begin
        w_code = 2'b00;
        if (w_illegal) begin
            w_code = 2'b01;
        end else if (w_conflict) begin
            w_code = 2'b10;
        end else if (w_stuck) begin
            w_code = 2'b11;
        end
    end
    assign w_fault = (w_code != 2'b00);

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_rec_inc = r_rec + REC_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_flash_nxt   = r_flash;
        w_rec_nxt     = r_rec;
        w_code_nxt    = r_code;
        w_trip_nxt    = r_trip;
        w_enter_fs    = 1'b0;
        w_ns_lamp_nxt = RED;
        w_we_lamp_nxt = RED;

        case (r_state)
            ST_NORMAL: begin
                if (w_fault) begin
                    if (FAULT_CONFIRM == 1) begin
                        w_enter_fs = 1'b1;
                    end else begin
                        w_state_nxt = ST_SUSPECT;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_SUSPECT: begin
                if (!w_fault) begin
                    w_state_nxt = ST_NORMAL;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == CONFIRM_L) begin
                    w_enter_fs = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_FAILSAFE: begin
                w_flash_nxt = (r_flash == FLASH_LAST) ? '0 : r_flash + FLASH_W'(1);
                if (clear_fault && !w_fault) begin
                    w_state_nxt = ST_RECOVER;
                    w_rec_nxt   = '0;
                end
            end
            ST_RECOVER: begin
                if (w_fault) begin
                    w_enter_fs = 1'b1;
                end else if (w_rec_inc == REC_L) begin
                    w_state_nxt = ST_NORMAL;
                    w_rec_nxt   = '0;
                    w_code_nxt  = 2'b00;
                end else begin
                    w_rec_nxt = w_rec_inc;
                end
            end
            default: w_state_nxt = ST_NORMAL;
        endcase

        if (w_enter_fs) begin
            w_state_nxt = ST_FAILSAFE;
            w_flash_nxt = '0;
            w_cnt_nxt   = '0;
            w_code_nxt  = w_code;
            if (r_trip != 8'hFF) begin
                w_trip_nxt = r_trip + 8'd1;
            end
        end

        // Lamps are driven from the state being entered so an unsafe aspect never reaches the drivers.
        case (w_state_nxt)
            ST_NORMAL: begin
                w_ns_lamp_nxt = ns_in;
                w_we_lamp_nxt = we_in;
            end
            ST_FAILSAFE: begin
                w_ns_lamp_nxt = (w_flash_nxt < HALF_L) ? YELLOW : DARK;
                w_we_lamp_nxt = (w_flash_nxt < HALF_L) ? YELLOW : DARK;
            end
            default: begin
                w_ns_lamp_nxt = RED;
                w_we_lamp_nxt = RED;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_NORMAL;
            r_cnt     <= '0;
            r_flash   <= '0;
            r_rec     <= '0;
            r_code    <= 2'b00;
            r_trip    <= 8'd0;
            r_ns_lamp <= RED;
            r_we_lamp <= RED;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_flash   <= w_flash_nxt;
            r_rec     <= w_rec_nxt;
            r_code    <= w_code_nxt;
            r_trip    <= w_trip_nxt;
            r_ns_lamp <= w_ns_lamp_nxt;
            r_we_lamp <= w_we_lamp_nxt;
        end
    end

    assign ns_lamp    = r_ns_lamp;
    assign we_lamp    = r_we_lamp;
    assign fault      = (r_state == ST_FAILSAFE) || (r_state == ST_RECOVER);
    assign fault_code = r_code;
    assign trip_count = r_trip;

endmodule
